bomb_bus_arbiter: RTL and testbench

Shares the single (X, Y) query/placement port of the bomb engine between the tile/explosion renderer and the two players' bomb-place buttons. Latches place requests, sequences each placement as set-up / fire / guard so the engine sees stable coordinates around a one-cycle place pulse, and time-slices renderer lookups with registered results. Sits between the player controllers, the VGA draw engine, and the bomb engine.

---
 rtl/bomb_pkg.sv | 12 +
 rtl/place_request_latch.sv | 34 +++
 rtl/bomb_bus_arbiter.sv | 128 ++++++++++++
 tb/tb_bomb_bus_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bomb_pkg.sv
// bomb_pkg: shared types and widths for the bomb engine bus arbiter
package bomb_pkg;
    localparam int X_W    = 9;
    localparam int Y_W    = 8;
    localparam int TILE_W = 4;
    localparam int CNT_W  = 8;
    typedef enum logic [2:0] {S_IDLE, S_P_SETUP, S_P_FIRE, S_P_GUARD, S_D_WAIT} state_t;
    typedef enum logic {PLAYER_P1 = 1'b0, PLAYER_P2 = 1'b1} player_t;
    function automatic player_t other(input player_t p);
        return p == PLAYER_P1 ? PLAYER_P2 : PLAYER_P1;
    endfunction
endpackage

// File: rtl/place_request_latch.sv
// place_request_latch: rising-edge request capture with pending flag and coordinates
module place_request_latch
    import bomb_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           req,
    input  logic [X_W-1:0] req_x,
    input  logic [Y_W-1:0] req_y,
    input  logic           clear,
    output logic           pend,
    output logic [X_W-1:0] cap_x,
    output logic [Y_W-1:0] cap_y
);
    logic prev;
    logic rise;
    assign rise = req & ~prev;
    // an edge landing on the clearing cycle starts a fresh request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev  <= 1'b0;
            pend  <= 1'b0;
            cap_x <= '0;
            cap_y <= '0;
        end else begin
            prev <= req;
            pend <= rise | (pend & ~clear);
            if (rise && (!pend || clear)) begin
                cap_x <= req_x;
                cap_y <= req_y;
            end
        end
    end
endmodule

// File: rtl/bomb_bus_arbiter.sv
// bomb_bus_arbiter: shares the bomb engine X/Y port between player placements and renderer lookups
module bomb_bus_arbiter
    import bomb_pkg::*;
#(
    parameter int PLACE_HOLD = 1,
    parameter int DRAW_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p1_req,
    input  logic              p2_req,
    input  logic [X_W-1:0]    p1_X,
    input  logic [X_W-1:0]    p2_X,
    input  logic [Y_W-1:0]    p1_Y,
    input  logic [Y_W-1:0]    p2_Y,
    input  logic              draw_req,
    input  logic [X_W-1:0]    draw_X,
    input  logic [Y_W-1:0]    draw_Y,
    output logic              draw_ack,
    output logic              draw_valid,
    output logic [TILE_W-1:0] draw_tile,
    output logic              draw_expl,
    output logic [X_W-1:0]    X,
    output logic [Y_W-1:0]    Y,
    output logic              placeP1,
    output logic              placeP2,
    input  logic [TILE_W-1:0] map_tile_id,
    input  logic              has_explosion,
    output logic              p1_done,
    output logic              p2_done
);
    state_t           state;
    player_t          rr, cur, pick;
    logic             draw_turn, draw_go, place_go;
    logic [CNT_W-1:0] cnt;
    logic             pend1, pend2;
    logic [X_W-1:0]   c1_x, c2_x;
    logic [Y_W-1:0]   c1_y, c2_y;

    place_request_latch u_p1 (
        .clk(clk), .reset(reset), .req(p1_req), .req_x(p1_X), .req_y(p1_Y),
        .clear(state == S_P_FIRE && cur == PLAYER_P1),
        .pend(pend1), .cap_x(c1_x), .cap_y(c1_y)
    );
    place_request_latch u_p2 (
        .clk(clk), .reset(reset), .req(p2_req), .req_x(p2_X), .req_y(p2_Y),
        .clear(state == S_P_FIRE && cur == PLAYER_P2),
        .pend(pend2), .cap_x(c2_x), .cap_y(c2_y)
    );

    // the renderer wins only on its turn or when no placement is waiting
    always_comb begin
        draw_go  = state == S_IDLE && draw_req && (draw_turn || !(pend1 || pend2));
        place_go = state == S_IDLE && !draw_go && (pend1 || pend2);
        pick     = (pend1 && pend2) ? rr : (pend1 ? PLAYER_P1 : PLAYER_P2);
    end
    assign draw_ack = draw_go;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            rr         <= PLAYER_P1;
            cur        <= PLAYER_P1;
            draw_turn  <= 1'b0;
            cnt        <= '0;
            X          <= '0;
            Y          <= '0;
            placeP1    <= 1'b0;
            placeP2    <= 1'b0;
            p1_done    <= 1'b0;
            p2_done    <= 1'b0;
            draw_valid <= 1'b0;
            draw_tile  <= '0;
            draw_expl  <= 1'b0;
        end else begin
            placeP1    <= 1'b0;
            placeP2    <= 1'b0;
            p1_done    <= 1'b0;
            p2_done    <= 1'b0;
            draw_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (draw_go) begin
                        X         <= draw_X;
                        Y         <= draw_Y;
                        draw_turn <= 1'b0;
                        cnt       <= CNT_W'(DRAW_LAT);
                        state     <= S_D_WAIT;
                    end else if (place_go) begin
                        cur   <= pick;
                        rr    <= other(pick);
                        X     <= pick == PLAYER_P1 ? c1_x : c2_x;
                        Y     <= pick == PLAYER_P1 ? c1_y : c2_y;
                        cnt   <= CNT_W'(PLACE_HOLD);
                        state <= S_P_SETUP;
                    end
                end
                S_P_SETUP: begin
                    if (cnt == CNT_W'(1)) begin
                        placeP1 <= cur == PLAYER_P1;
                        placeP2 <= cur == PLAYER_P2;
                        p1_done <= cur == PLAYER_P1;
                        p2_done <= cur == PLAYER_P2;
                        state   <= S_P_FIRE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_P_FIRE: state <= S_P_GUARD;
                S_P_GUARD: begin
                    draw_turn <= 1'b1;
                    state     <= S_IDLE;
                end
                S_D_WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        draw_tile  <= map_tile_id;
                        draw_expl  <= has_explosion;
                        draw_valid <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bomb_bus_arbiter.sv
// tb_bomb_bus_arbiter: scoreboard bench with directed scenarios and randomized traffic
module tb_bomb_bus_arbiter;
    localparam int PH = 2;
    localparam int DL = 1;

    logic       clk = 0, reset = 0;
    logic       p1_req = 0, p2_req = 0, draw_req = 0;
    logic [8:0] p1_X = 0, p2_X = 0, draw_X = 0;
    logic [7:0] p1_Y = 0, p2_Y = 0, draw_Y = 0;
    logic       draw_ack, draw_valid, draw_expl, placeP1, placeP2, p1_done, p2_done;
    logic [3:0] draw_tile, map_tile_id;
    logic       has_explosion;
    logic [8:0] X;
    logic [7:0] Y;

    function automatic logic [3:0] eng_tile(input logic [8:0] x, input logic [7:0] y);
        return x[3:0] ^ y[3:0] ^ 4'hB;
    endfunction
    function automatic logic eng_expl(input logic [8:0] x, input logic [7:0] y);
        return x[1] ^ y[2];
    endfunction
    assign map_tile_id   = eng_tile(X, Y);
    assign has_explosion = eng_expl(X, Y);

    bomb_bus_arbiter #(.PLACE_HOLD(PH), .DRAW_LAT(DL)) dut (
        .clk(clk), .reset(reset),
        .p1_req(p1_req), .p2_req(p2_req), .p1_X(p1_X), .p2_X(p2_X), .p1_Y(p1_Y), .p2_Y(p2_Y),
        .draw_req(draw_req), .draw_X(draw_X), .draw_Y(draw_Y),
        .draw_ack(draw_ack), .draw_valid(draw_valid), .draw_tile(draw_tile), .draw_expl(draw_expl),
        .X(X), .Y(Y), .placeP1(placeP1), .placeP2(placeP2),
        .map_tile_id(map_tile_id), .has_explosion(has_explosion),
        .p1_done(p1_done), .p2_done(p2_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0, miscompares = 0;
    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {int x; int y;} coord_t;
    typedef struct {int tile; int expl; int due;} dres_t;
    coord_t q1[$], q2[$];
    dres_t  dq[$];
    int     ev[$];
    int     n1 = 0, n2 = 0, last_x2 = 0, last_y2 = 0;
    bit     mpend1, mpend2, mprev1, mprev2, guard;
    int     gx, gy, px, py, stable;

    // reference model and scoreboard monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!reset) begin
            q1.delete(); q2.delete(); dq.delete();
            mpend1 = 0; mpend2 = 0; mprev1 = 0; mprev2 = 0; guard = 0; stable = 0;
        end else begin
            coord_t c;
            dres_t  d;
            if (int'(X) == px && int'(Y) == py) stable++; else stable = 1;
            px = int'(X); py = int'(Y);
            chk("place_overlap", int'(placeP1 & placeP2), 0);
            chk("p1_done_match", int'(p1_done), int'(placeP1));
            chk("p2_done_match", int'(p2_done), int'(placeP2));
            if (guard) begin
                chk("guard_x", int'(X), gx);
                chk("guard_y", int'(Y), gy);
                guard = 0;
            end
            if (placeP1 || placeP2) begin
                chk("place_hold", int'(stable >= PH + 1), 1);
                gx = int'(X); gy = int'(Y); guard = 1;
                ev.push_back(placeP1 ? 1 : 2);
            end
            if (placeP1) begin
                n1++;
                chk("p1_queued", int'(q1.size() > 0), 1);
                if (q1.size() > 0) begin
                    c = q1.pop_front();
                    chk("p1_x", int'(X), c.x);
                    chk("p1_y", int'(Y), c.y);
                end
            end
            if (placeP2) begin
                n2++; last_x2 = int'(X); last_y2 = int'(Y);
                chk("p2_queued", int'(q2.size() > 0), 1);
                if (q2.size() > 0) begin
                    c = q2.pop_front();
                    chk("p2_x", int'(X), c.x);
                    chk("p2_y", int'(Y), c.y);
                end
            end
            if (draw_valid) begin
                chk("draw_queued", int'(dq.size() > 0), 1);
                if (dq.size() > 0) begin
                    d = dq.pop_front();
                    chk("draw_tile", int'(draw_tile), d.tile);
                    chk("draw_expl", int'(draw_expl), d.expl);
                    chk("draw_latency", cyc, d.due);
                end
            end
            if (draw_ack) begin
                dq.push_back('{int'(eng_tile(draw_X, draw_Y)), int'(eng_expl(draw_X, draw_Y)), cyc + DL + 1});
                ev.push_back(3);
            end
            if (p1_req && !mprev1 && (!mpend1 || placeP1)) begin
                q1.push_back('{int'(p1_X), int'(p1_Y)});
                mpend1 = 1;
            end else if (placeP1) mpend1 = 0;
            if (p2_req && !mprev2 && (!mpend2 || placeP2)) begin
                q2.push_back('{int'(p2_X), int'(p2_Y)});
                mpend2 = 1;
            end else if (placeP2) mpend2 = 0;
            mprev1 = p1_req;
            mprev2 = p2_req;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        chk({tag, "_placeP1"}, int'(placeP1), 0);
        chk({tag, "_placeP2"}, int'(placeP2), 0);
        chk({tag, "_done"}, int'(p1_done | p2_done), 0);
        chk({tag, "_valid"}, int'(draw_valid), 0);
        chk({tag, "_X"}, int'(X), 0);
        chk({tag, "_Y"}, int'(Y), 0);
    endtask

    task automatic do_reset();
        reset = 0;
        p1_req = 0; p2_req = 0; draw_req = 0;
        step(); step();
        check_idle("rst");
        step();
        reset = 1;
        check_idle("rel");
        step();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        // draw lookup, coordinates changed after the ack
        draw_X = 100; draw_Y = 60; draw_req = 1;
        @(negedge clk);
        chk("t1_ack", int'(draw_ack), 1);
        step();
        draw_req = 0; draw_X = 7; draw_Y = 9;
        @(negedge clk);
        chk("t1_X", int'(X), 100);
        chk("t1_Y", int'(Y), 60);
        chk("t1_ack_low", int'(draw_ack), 0);
        for (int k = 2; k <= DL; k++) begin
            step(); @(negedge clk);
            chk("t1_early_valid", int'(draw_valid), 0);
        end
        step(); @(negedge clk);
        chk("t1_valid", int'(draw_valid), 1);
        chk("t1_tile", int'(draw_tile), 3);
        chk("t1_expl", int'(draw_expl), 1);
        step(); @(negedge clk);
        chk("t1_valid_pulse", int'(draw_valid), 0);
        chk("t1_tile_hold", int'(draw_tile), 3);

        // single P1 placement timing
        do_reset();
        p1_X = 88; p1_Y = 48; p1_req = 1;
        step();
        p1_req = 0; p1_X = 5; p1_Y = 5;
        for (int k = 1; k <= PH; k++) begin
            step(); @(negedge clk);
            chk("t2_setup_X", int'(X), 88);
            chk("t2_setup_Y", int'(Y), 48);
            chk("t2_setup_place", int'(placeP1), 0);
        end
        step(); @(negedge clk);
        chk("t2_fire", int'(placeP1), 1);
        chk("t2_done", int'(p1_done), 1);
        chk("t2_fire_X", int'(X), 88);
        step(); @(negedge clk);
        chk("t2_guard_place", int'(placeP1), 0);
        chk("t2_guard_X", int'(X), 88);
        chk("t2_guard_Y", int'(Y), 48);

        // fairness with draw held
        do_reset();
        ev.delete();
        p1_X = 11; p1_Y = 12; p2_X = 21; p2_Y = 22; p1_req = 1; p2_req = 1;
        step();
        p1_req = 0; p2_req = 0; draw_req = 1; draw_X = 33; draw_Y = 44;
        for (int k = 0; k < 100 && ev.size() < 4; k++) step();
        draw_req = 0;
        chk("t3_event_count", int'(ev.size() >= 4), 1);
        if (ev.size() >= 4) begin
            chk("t3_ev0_P1", ev[0], 1);
            chk("t3_ev1_draw", ev[1], 3);
            chk("t3_ev2_P2", ev[2], 2);
            chk("t3_ev3_draw", ev[3], 3);
        end
        repeat (10) step();

        // repeated P2 edges merge while pending
        do_reset();
        n2 = 0;
        p1_X = 88; p1_Y = 48; p1_req = 1;
        step();
        p1_req = 0; p2_X = 10; p2_Y = 20; p2_req = 1;
        step();
        p2_req = 0; p2_X = 30; p2_Y = 40;
        step();
        p2_req = 1;
        step();
        p2_req = 0; p2_X = 50; p2_Y = 60;
        step();
        p2_req = 1;
        step();
        p2_req = 0;
        repeat (20) step();
        chk("t4_p2_count", n2, 1);
        chk("t4_p2_x", last_x2, 10);
        chk("t4_p2_y", last_y2, 20);

        // reset during setup aborts the placement and drops pending work
        do_reset();
        n1 = 0; n2 = 0;
        p1_X = 1; p1_Y = 2; p1_req = 1;
        step();
        p1_req = 0; p2_X = 3; p2_Y = 4; p2_req = 1;
        step();
        reset = 0; p2_req = 0;
        @(negedge clk);
        chk("t6_rst_place", int'(placeP1), 0);
        chk("t6_rst_X", int'(X), 0);
        step(); step();
        reset = 1;
        repeat (20) step();
        chk("t6_no_p1", n1, 0);
        chk("t6_no_p2", n2, 0);

        // randomized traffic against the scoreboard
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            step();
            if ($urandom_range(0, 3) == 0) p1_req = ~p1_req;
            if ($urandom_range(0, 3) == 0) p2_req = ~p2_req;
            p1_X = 9'($urandom); p1_Y = 8'($urandom);
            p2_X = 9'($urandom); p2_Y = 8'($urandom);
            draw_req = $urandom_range(0, 2) != 0;
            draw_X = 9'($urandom); draw_Y = 8'($urandom);
        end
        step();
        p1_req = 0; p2_req = 0; draw_req = 0;
        for (int k = 0; k < 300 && (q1.size() + q2.size() + dq.size()) > 0; k++) step();
        repeat (5) step();
        chk("drain_q1", q1.size(), 0);
        chk("drain_q2", q2.size(), 0);
        chk("drain_dq", dq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
